// File: rtl/axi4lite_read_arbiter.sv
// axi4lite_read_arbiter: shares one AXI4-lite read master between instruction fetch and load unit
module axi4lite_read_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_arvalid,
  output logic                  if_arready,
  input  logic [ADDR_WIDTH-1:0] if_araddr,
  output logic                  if_rvalid,
  input  logic                  if_rready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic [1:0]            if_rresp,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  input  logic [ADDR_WIDTH-1:0] lsu_araddr,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state_q, state_d;
  logic grant_q, last_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic pick_lsu, accept, in_data, if_sel, lsu_sel;
  // grant_q/last_q: 1 = LSU, 0 = IF
  assign pick_lsu = lsu_arvalid && (!if_arvalid || !ROUND_ROBIN || !last_q);
  assign accept = (state_q == IDLE) && !rst && (if_arvalid || lsu_arvalid);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q <= 1'b0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q <= pick_lsu;
        last_q <= pick_lsu;
        addr_q <= pick_lsu ? lsu_araddr : if_araddr;
      end
    end
  end
  always_comb begin
    in_data = state_q == DATA;
    if_sel = in_data && !grant_q;
    lsu_sel = in_data && grant_q;
    if_arready = accept && !pick_lsu;
    lsu_arready = accept && pick_lsu;
    m_arvalid = state_q == ADDR;
    m_araddr = addr_q;
    m_arprot = (state_q == ADDR && !grant_q) ? 3'b100 : 3'b000;
    m_rready = in_data && (grant_q ? lsu_rready : if_rready);
    if_rvalid = if_sel && m_rvalid;
    if_rdata = if_sel ? m_rdata : '0;
    if_rresp = if_sel ? m_rresp : 2'b00;
    lsu_rvalid = lsu_sel && m_rvalid;
    lsu_rdata = lsu_sel ? m_rdata : '0;
    lsu_rresp = lsu_sel ? m_rresp : 2'b00;
    state_d = (state_q == IDLE && accept) ? ADDR :
              (state_q == ADDR && m_arready) ? DATA :
              (in_data && m_rvalid && m_rready) ? IDLE : state_q;
  end
endmodule

// File: tb/tb_axi4lite_read_arbiter.sv
// tb_axi4lite_read_arbiter: directed and random checks against a transaction-level arbitration model
module tb_axi4lite_read_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic if_arvalid = 0, if_rready = 0, lsu_arvalid = 0, lsu_rready = 0;
  logic m_arready = 0, m_rvalid = 0;
  logic [63:0] if_araddr = '0, lsu_araddr = '0, m_rdata = '0;
  logic [1:0] m_rresp = '0;
  logic a_if_arready, a_if_rvalid, a_lsu_arready, a_lsu_rvalid, a_m_arvalid, a_m_rready;
  logic b_if_arready, b_if_rvalid, b_lsu_arready, b_lsu_rvalid, b_m_arvalid, b_m_rready;
  logic [63:0] a_if_rdata, a_lsu_rdata, a_m_araddr, b_if_rdata, b_lsu_rdata, b_m_araddr;
  logic [1:0] a_if_rresp, a_lsu_rresp, b_if_rresp, b_lsu_rresp;
  logic [2:0] a_m_arprot, b_m_arprot;
  int n_chk = 0, n_fail = 0;
  bit last_m = 1'b0;

  always #5 clk = ~clk;

  axi4lite_read_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_arvalid(if_arvalid), .if_arready(a_if_arready), .if_araddr(if_araddr),
    .if_rvalid(a_if_rvalid), .if_rready(if_rready), .if_rdata(a_if_rdata), .if_rresp(a_if_rresp),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(a_lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_rvalid(a_lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(a_lsu_rdata), .lsu_rresp(a_lsu_rresp),
    .m_arvalid(a_m_arvalid), .m_arready(m_arready), .m_araddr(a_m_araddr), .m_arprot(a_m_arprot),
    .m_rvalid(m_rvalid), .m_rready(a_m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp));

  axi4lite_read_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ROUND_ROBIN(1'b0)) dut_fixed (
    .clk(clk), .rst(rst),
    .if_arvalid(if_arvalid), .if_arready(b_if_arready), .if_araddr(if_araddr),
    .if_rvalid(b_if_rvalid), .if_rready(if_rready), .if_rdata(b_if_rdata), .if_rresp(b_if_rresp),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(b_lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_rvalid(b_lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(b_lsu_rdata), .lsu_rresp(b_lsu_rresp),
    .m_arvalid(b_m_arvalid), .m_arready(m_arready), .m_araddr(b_m_araddr), .m_arprot(b_m_arprot),
    .m_rvalid(m_rvalid), .m_rready(b_m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Round-robin reference: a lone requester wins, contention goes to the port not served last
  function automatic bit winner(input bit ifv, input bit lsuv, input bit last);
    return !ifv ? 1'b1 : !lsuv ? 1'b0 : !last;
  endfunction

  task automatic run_txn(input bit ifv, input bit lsuv, input logic [63:0] ia, input logic [63:0] la,
                         input int ard, input int rvd, input int rrd,
                         input logic [63:0] d, input logic [1:0] rs);
    bit w;
    logic [63:0] ea;
    if_arvalid = ifv; lsu_arvalid = lsuv; if_araddr = ia; lsu_araddr = la;
    m_arready = 0; m_rvalid = 0; if_rready = 0; lsu_rready = 0;
    #1;
    w = winner(ifv, lsuv, last_m);
    ea = w ? la : ia;
    chk("idle_if_arready", a_if_arready, !w);
    chk("idle_lsu_arready", a_lsu_arready, w);
    chk("idle_m_arvalid", a_m_arvalid, 0);
    tick();
    last_m = w;
    if (w) lsu_arvalid = 0; else if_arvalid = 0;
    for (int i = 0; i <= ard; i++) begin
      m_arready = (i == ard);
      #1;
      chk("addr_m_arvalid", a_m_arvalid, 1);
      chk("addr_m_araddr", a_m_araddr, ea);
      chk("addr_m_arprot", a_m_arprot, w ? 3'b000 : 3'b100);
      chk("addr_arready", {a_if_arready, a_lsu_arready}, 0);
      chk("addr_m_rready", a_m_rready, 0);
      tick();
    end
    m_arready = 0; if_arvalid = 0; lsu_arvalid = 0;
    if (w) lsu_rready = 1; else if_rready = 1;
    for (int i = 0; i < rvd; i++) begin
      #1;
      chk("wait_m_rready", a_m_rready, 1);
      chk("wait_rvalid", {a_if_rvalid, a_lsu_rvalid}, 0);
      chk("wait_m_arvalid", a_m_arvalid, 0);
      tick();
    end
    m_rvalid = 1; m_rdata = d; m_rresp = rs;
    for (int i = 0; i <= rrd; i++) begin
      if (w) lsu_rready = (i == rrd); else if_rready = (i == rrd);
      #1;
      chk("data_rvalid", w ? a_lsu_rvalid : a_if_rvalid, 1);
      chk("data_rdata", w ? a_lsu_rdata : a_if_rdata, d);
      chk("data_rresp", w ? a_lsu_rresp : a_if_rresp, rs);
      chk("data_other_rvalid", w ? a_if_rvalid : a_lsu_rvalid, 0);
      chk("data_m_rready", a_m_rready, i == rrd);
      tick();
    end
    m_rvalid = 0; if_rready = 0; lsu_rready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    bit w, ifv, lsuv;
    logic [63:0] ea;
    rst = 1; if_arvalid = 1; lsu_arvalid = 1; lsu_araddr = 64'h18;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_arready", {a_if_arready, a_lsu_arready, b_if_arready, b_lsu_arready}, 0);
      chk("rst_rvalid", {a_if_rvalid, a_lsu_rvalid, b_if_rvalid, b_lsu_rvalid}, 0);
      chk("rst_m_arvalid", {a_m_arvalid, b_m_arvalid}, 0);
      chk("rst_m_arprot", a_m_arprot, 0);
    end
    rst = 0;
    last_m = 0;
    #1;
    chk("first_grant_fixed_lsu", b_lsu_arready, 1);
    run_txn(1, 1, 64'h0, 64'h18, 0, 0, 0, 64'hCAFE_0000_0000_0001, 2'b00);
    run_txn(1, 0, 64'h10, 64'h0, 0, 2, 0, 64'h11223344AADDEEFF, 2'b00);
    run_txn(1, 0, 64'h40, 64'h0, 5, 1, 3, 64'h0123_4567_89AB_CDEF, 2'b00);
    run_txn(0, 1, 64'h0, 64'h58, 1, 0, 0, 64'hDEAD_BEEF_0000_0000, 2'b10);
    run_txn(1, 1, 64'h60, 64'h68, 0, 0, 0, 64'h5555_AAAA_5555_AAAA, 2'b11);
    run_txn(1, 1, 64'h70, 64'h78, 0, 1, 1, 64'hAAAA_5555_AAAA_5555, 2'b00);

    rst = 1;
    tick();
    rst = 0;
    last_m = 0;
    if_arvalid = 1; lsu_arvalid = 1; if_araddr = 64'h0; lsu_araddr = 64'h18;
    m_arready = 1; m_rvalid = 1; m_rdata = 64'h77; m_rresp = 0; if_rready = 1; lsu_rready = 1;
    for (int t = 0; t < 4; t++) begin
      w = winner(1, 1, last_m);
      ea = w ? 64'h18 : 64'h0;
      #1;
      chk("rr_accept", {a_if_arready, a_lsu_arready}, {!w, w});
      chk("fixed_accept", {b_if_arready, b_lsu_arready}, 2'b01);
      tick();
      last_m = w;
      chk("rr_m_araddr", a_m_araddr, ea);
      chk("rr_m_arprot", a_m_arprot, w ? 3'b000 : 3'b100);
      chk("fixed_m_araddr", b_m_araddr, 64'h18);
      chk("fixed_m_arprot", b_m_arprot, 3'b000);
      chk("fixed_if_arready", b_if_arready, 0);
      tick();
      chk("rr_rvalid", {a_if_rvalid, a_lsu_rvalid}, {!w, w});
      chk("fixed_lsu_rvalid", b_lsu_rvalid, 1);
      tick();
    end
    if_arvalid = 0; lsu_arvalid = 0; m_arready = 0; m_rvalid = 0; if_rready = 0; lsu_rready = 0;

    if_arvalid = 1; if_araddr = 64'h30; m_arready = 1;
    #1;
    chk("mid_accept", a_if_arready, 1);
    tick();
    if_arvalid = 0;
    tick();
    m_arready = 0; if_rready = 1;
    #1;
    chk("mid_in_data", a_m_rready, 1);
    rst = 1;
    tick();
    rst = 0; m_rvalid = 1;
    #1;
    chk("mid_rst_m_rready", a_m_rready, 0);
    chk("mid_rst_if_rvalid", a_if_rvalid, 0);
    chk("mid_rst_m_arvalid", a_m_arvalid, 0);
    chk("mid_rst_arready", {a_if_arready, a_lsu_arready}, 0);
    m_rvalid = 0; if_rready = 0;
    last_m = 0;
    run_txn(0, 1, 64'h0, 64'h20, 0, 1, 0, 64'h2020_2020_2020_2020, 2'b00);

    for (int n = 0; n < 30; n++) begin
      ifv = 1'($urandom_range(0, 1));
      lsuv = ifv ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(ifv, lsuv, {32'h0, $urandom} & 64'hFFFF_FFF8, {32'h0, $urandom} & 64'hFFFF_FFF8,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              {$urandom, $urandom}, 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
